// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: round-robin sequencer driving a bank of JK flip-flops; define JK_CHECK_EN for Q readback verification
module jk_bank_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   mask,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [WIDTH-1:0]        j_vec,
  output logic [WIDTH-1:0]        k_vec,
  input  logic [WIDTH-1:0]        q_vec
);
  localparam int PW = $clog2(NREQ);
`ifdef JK_CHECK_EN
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRIVE} state_t;
`endif
  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, win;
  logic [NREQ-1:0]   sel;
  logic              hit, fire;
  logic [1:0]        op_w;
  logic [WIDTH-1:0]  mask_w, j_dec, k_dec, j_q, k_q, j_d, k_d;
  // Round-robin search starting at ptr_q; the first requester found wins
  always_comb begin
    hit = 1'b0;
    win = ptr_q;
    sel = '0;
    for (int o = 0; o < NREQ; o++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!hit && req[i] && i == (int'(ptr_q) + o) % NREQ) begin
          hit    = 1'b1;
          win    = PW'(i);
          sel[i] = 1'b1;
        end
      end
    end
  end
  // Grant is decoded in the IDLE cycle itself so the next grant can follow CHECK without a gap
  assign fire = hit && state_q == IDLE && rst_n;
  assign gnt  = fire ? sel : '0;
  assign ptr_d = fire ? ((int'(win) == NREQ - 1) ? '0 : win + 1'b1) : ptr_q;
  // Capture the winner's command and decode it onto J/K
  always_comb begin
    op_w   = '0;
    mask_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) begin
        op_w   = op[2*i +: 2];
        mask_w = mask[WIDTH*i +: WIDTH];
      end
    end
  end
  assign j_dec = op_w[1] ? mask_w : '0;
  assign k_dec = op_w[0] ? mask_w : '0;
  assign j_d   = fire ? j_dec : '0;
  assign k_d   = fire ? k_dec : '0;
  // Next-state logic for the operation sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = fire ? DRIVE : IDLE;
`ifdef JK_CHECK_EN
      DRIVE:   state_d = CHECK;
`else
      DRIVE:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end
  // State, pointer and J/K registers; J/K are loaded only for the single DRIVE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end
  assign j_vec = j_q;
  assign k_vec = k_q;
  assign busy  = state_q != IDLE;
`ifdef JK_CHECK_EN
  logic [WIDTH-1:0] exp_q, exp_d;
  assign exp_d = fire ? ((j_dec & ~q_vec) | (~k_dec & q_vec)) : exp_q;
  // Expected bank contents computed from the Q snapshot taken at grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q <= '0;
    else        exp_q <= exp_d;
  end
  assign done = state_q == CHECK;
  assign err  = done && (q_vec != exp_q);
`else
  logic unused_q;
  assign unused_q = ^q_vec;
  assign done     = state_q == DRIVE;
  assign err      = 1'b0;
`endif
endmodule
